// File: rtl/store_buffer.sv
// Post-retirement store buffer: circular FIFO of retired stores, drained in order to the
// D-cache over a valid/ack handshake, with same-cycle store-to-load forwarding.
module store_buffer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SB_CAPACITY = 4,
    parameter int unsigned SB_LEN      = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              sq2sb_valid,
    input  logic [XLEN-1:0]   sq2sb_pc,
    input  logic [XLEN-1:0]   sq2sb_addr,
    input  logic [XLEN-1:0]   sq2sb_data,
    input  logic [3:0]        sq2sb_store_byte,

    output logic              sb_full,
    output logic              sb_empty,
    output logic [SB_LEN:0]   sb_count,
    output logic              sb_overflow,

    output logic              sb2cache_req_valid,
    output logic [XLEN-1:0]   sb2cache_addr,
    output logic [XLEN-1:0]   sb2cache_data,
    output logic [3:0]        sb2cache_store_byte,
    input  logic              cache2sb_ack,

    input  logic              lb2sb_req_valid,
    input  logic [XLEN-1:0]   lb2sb_addr,
    input  logic [3:0]        lb2sb_load_byte,
    output logic              sb_fwd_hit,
    output logic              sb_fwd_partial,
    output logic [XLEN-1:0]   sb_fwd_data
);

    typedef enum logic {
        StIdle,
        StBusy
    } drain_state_e;

    localparam logic [SB_LEN-1:0] PtrOne  = SB_LEN'(1);
    localparam logic [SB_LEN:0]   CntOne  = (SB_LEN + 1)'(1);
    localparam logic [SB_LEN:0]   CntFull = (SB_LEN + 1)'(SB_CAPACITY);

    // Entry storage
    logic [SB_CAPACITY-1:0] valid_q;
    logic [XLEN-1:0]        addr_q [SB_CAPACITY];
    logic [XLEN-1:0]        data_q [SB_CAPACITY];
    logic [3:0]             mask_q [SB_CAPACITY];

    logic [SB_LEN-1:0] head_q, head_d;
    logic [SB_LEN-1:0] tail_q, tail_d;
    logic [SB_LEN:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    drain_state_e      state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   req_data_q, req_data_d;
    logic [3:0]        req_mask_q, req_mask_d;

    logic push_ok;
    logic pop;

    // PC is carried by the SQ packet but not needed once the store has retired.
    logic unused_inputs;
    assign unused_inputs = ^{sq2sb_pc, lb2sb_addr[1:0]};

    assign sb_full  = (count_q == CntFull);
    assign sb_empty = (count_q == '0);
    assign sb_count = count_q;
    assign sb_overflow = overflow_q;
    assign push_ok  = sq2sb_valid && !sb_full;

    assign sb2cache_req_valid  = req_valid_q;
    assign sb2cache_addr       = req_addr_q;
    assign sb2cache_data       = req_data_q;
    assign sb2cache_store_byte = req_mask_q;

    // Drain FSM next-state and request fields
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_mask_d  = req_mask_q;
        pop         = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d     = StBusy;
                    req_valid_d = 1'b1;
                    req_addr_d  = addr_q[head_q];
                    req_data_d  = data_q[head_q];
                    req_mask_d  = mask_q[head_q];
                end
            end
            StBusy: begin
                if (cache2sb_ack) begin
                    pop         = 1'b1;
                    req_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pointer, count and overflow bookkeeping
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            tail_d = tail_q + PtrOne;
        end
        if (pop) begin
            head_d = head_q + PtrOne;
        end
        if (push_ok && !pop) begin
            count_d = count_q + CntOne;
        end else if (pop && !push_ok) begin
            count_d = count_q - CntOne;
        end
        if (sq2sb_valid && sb_full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            state_q     <= StIdle;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_mask_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_mask_q  <= req_mask_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < SB_CAPACITY; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= sq2sb_addr;
                data_q[tail_q]  <= sq2sb_data;
                mask_q[tail_q]  <= sq2sb_store_byte;
            end
            // A push never targets the head slot while it is popped: pushes are refused when full.
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
        end
    end

    // Forwarding: walk oldest to youngest so the last match seen is the youngest one.
    logic [SB_LEN-1:0] scan_idx;
    logic              fwd_match;
    logic [XLEN-1:0]   fwd_data_sel;
    logic [3:0]        fwd_mask_sel;

    always_comb begin
        scan_idx     = '0;
        fwd_match    = 1'b0;
        fwd_data_sel = '0;
        fwd_mask_sel = '0;
        for (int unsigned i = 0; i < SB_CAPACITY; i++) begin
            scan_idx = head_q + SB_LEN'(i);
            if (valid_q[scan_idx] && (addr_q[scan_idx][XLEN-1:2] == lb2sb_addr[XLEN-1:2])) begin
                fwd_match    = 1'b1;
                fwd_data_sel = data_q[scan_idx];
                fwd_mask_sel = mask_q[scan_idx];
            end
        end
    end

    always_comb begin
        sb_fwd_hit     = 1'b0;
        sb_fwd_partial = 1'b0;
        sb_fwd_data    = '0;
        if (lb2sb_req_valid && fwd_match) begin
            if ((fwd_mask_sel & lb2sb_load_byte) == lb2sb_load_byte) begin
                sb_fwd_hit  = 1'b1;
                sb_fwd_data = fwd_data_sel;
            end else begin
                sb_fwd_partial = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain handshake, full/overflow,
// forwarding priority and pointer wrap, asynchronous reset mid-drain.
module tb_store_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        sq2sb_valid;
    logic [31:0] sq2sb_pc;
    logic [31:0] sq2sb_addr;
    logic [31:0] sq2sb_data;
    logic [3:0]  sq2sb_store_byte;
    logic        sb_full;
    logic        sb_empty;
    logic [2:0]  sb_count;
    logic        sb_overflow;
    logic        sb2cache_req_valid;
    logic [31:0] sb2cache_addr;
    logic [31:0] sb2cache_data;
    logic [3:0]  sb2cache_store_byte;
    logic        cache2sb_ack;
    logic        lb2sb_req_valid;
    logic [31:0] lb2sb_addr;
    logic [3:0]  lb2sb_load_byte;
    logic        sb_fwd_hit;
    logic        sb_fwd_partial;
    logic [31:0] sb_fwd_data;

    int n_checks = 0;
    int n_errors = 0;

    store_buffer dut (
        .clock               (clock),
        .reset               (reset),
        .sq2sb_valid         (sq2sb_valid),
        .sq2sb_pc            (sq2sb_pc),
        .sq2sb_addr          (sq2sb_addr),
        .sq2sb_data          (sq2sb_data),
        .sq2sb_store_byte    (sq2sb_store_byte),
        .sb_full             (sb_full),
        .sb_empty            (sb_empty),
        .sb_count            (sb_count),
        .sb_overflow         (sb_overflow),
        .sb2cache_req_valid  (sb2cache_req_valid),
        .sb2cache_addr       (sb2cache_addr),
        .sb2cache_data       (sb2cache_data),
        .sb2cache_store_byte (sb2cache_store_byte),
        .cache2sb_ack        (cache2sb_ack),
        .lb2sb_req_valid     (lb2sb_req_valid),
        .lb2sb_addr          (lb2sb_addr),
        .lb2sb_load_byte     (lb2sb_load_byte),
        .sb_fwd_hit          (sb_fwd_hit),
        .sb_fwd_partial      (sb_fwd_partial),
        .sb_fwd_data         (sb_fwd_data)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        sq2sb_valid      = 1'b1;
        sq2sb_pc         = a ^ 32'h8000_0000;
        sq2sb_addr       = a;
        sq2sb_data       = d;
        sq2sb_store_byte = m;
        tick();
        sq2sb_valid      = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, input logic [3:0] m);
        lb2sb_req_valid = 1'b1;
        lb2sb_addr      = a;
        lb2sb_load_byte = m;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #10;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        sq2sb_valid = 1'b0; sq2sb_pc = '0; sq2sb_addr = '0; sq2sb_data = '0;
        sq2sb_store_byte = '0; cache2sb_ack = 1'b0;
        lb2sb_req_valid = 1'b0; lb2sb_addr = '0; lb2sb_load_byte = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_count", 32'(sb_count), 32'd0);
        check("rst_empty", 32'(sb_empty), 32'd1);
        check("rst_req",   32'(sb2cache_req_valid), 32'd0);
        reset = 1'b0;
        tick();

        // 1: single store, request one edge after the push edge
        push(32'h100, 32'hDEAD_BEEF, 4'hF);
        check("t1_count", 32'(sb_count), 32'd1);
        check("t1_req_early", 32'(sb2cache_req_valid), 32'd0);
        tick();
        check("t1_req", 32'(sb2cache_req_valid), 32'd1);
        check("t1_addr", sb2cache_addr, 32'h100);
        check("t1_data", sb2cache_data, 32'hDEAD_BEEF);
        check("t1_mask", 32'(sb2cache_store_byte), 32'hF);
        lookup(32'h100, 4'hF);
        check("t1_fwd_hit", 32'(sb_fwd_hit), 32'd1);
        check("t1_fwd_data", sb_fwd_data, 32'hDEAD_BEEF);
        lb2sb_req_valid = 1'b0;
        tick();
        check("t1_held", 32'(sb2cache_req_valid), 32'd1);

        // 2: ack pops, then the one-cycle bubble between drains
        cache2sb_ack = 1'b1;
        tick();
        cache2sb_ack = 1'b0;
        check("t2_req", 32'(sb2cache_req_valid), 32'd0);
        check("t2_count", 32'(sb_count), 32'd0);
        check("t2_empty", 32'(sb_empty), 32'd1);
        push(32'h104, 32'h0000_0104, 4'hF);
        push(32'h108, 32'h0000_0108, 4'hF);
        check("t2_req_a", sb2cache_addr, 32'h104);
        check("t2_count2", 32'(sb_count), 32'd2);
        cache2sb_ack = 1'b1;
        tick();
        check("t2_bubble", 32'(sb2cache_req_valid), 32'd0);
        check("t2_count3", 32'(sb_count), 32'd1);
        tick();
        check("t2_req_b", 32'(sb2cache_req_valid), 32'd1);
        check("t2_addr_b", sb2cache_addr, 32'h108);
        check("t2_idle_ack", 32'(sb_count), 32'd1);
        tick();
        cache2sb_ack = 1'b0;
        check("t2_drained", 32'(sb_count), 32'd0);

        // 3: fill, overflow, push+ack while full
        for (int i = 0; i < 4; i++) begin
            push(32'h300 + 32'(4 * i), 32'(i + 1), 4'hF);
        end
        check("t3_full", 32'(sb_full), 32'd1);
        check("t3_count", 32'(sb_count), 32'd4);
        check("t3_ovf0", 32'(sb_overflow), 32'd0);
        check("t3_req_addr", sb2cache_addr, 32'h300);
        push(32'h310, 32'h5, 4'hF);
        check("t3_ovf", 32'(sb_overflow), 32'd1);
        check("t3_count_hold", 32'(sb_count), 32'd4);
        lookup(32'h310, 4'hF);
        check("t3_rejected_fwd", 32'(sb_fwd_hit), 32'd0);
        lb2sb_req_valid = 1'b0;
        cache2sb_ack = 1'b1;
        push(32'h314, 32'h6, 4'hF);
        cache2sb_ack = 1'b0;
        check("t3_count_pp", 32'(sb_count), 32'd3);
        check("t3_ovf_sticky", 32'(sb_overflow), 32'd1);
        check("t3_not_full", 32'(sb_full), 32'd0);
        do_reset();
        check("t3_ovf_rst", 32'(sb_overflow), 32'd0);

        // 4: youngest match decides, partial coverage
        push(32'h200, 32'h1111_1111, 4'hF);
        push(32'h200, 32'h2222_2222, 4'h1);
        lookup(32'h200, 4'h1);
        check("t4_hit", 32'(sb_fwd_hit), 32'd1);
        check("t4_data", sb_fwd_data, 32'h2222_2222);
        lookup(32'h203, 4'hF);
        check("t4_partial", 32'(sb_fwd_partial), 32'd1);
        check("t4_nohit", 32'(sb_fwd_hit), 32'd0);
        check("t4_pdata", sb_fwd_data, 32'd0);
        lookup(32'h200, 4'h2);
        check("t4_young_partial", 32'(sb_fwd_partial), 32'd1);
        lookup(32'h204, 4'h1);
        check("t4_miss", 32'({sb_fwd_hit, sb_fwd_partial}), 32'd0);
        lb2sb_req_valid = 1'b0;
        #1;
        check("t4_invalid", 32'(sb_fwd_hit), 32'd0);
        do_reset();

        // 5: wrap pointers, then oldest entry in slot 3
        for (int i = 0; i < 7; i++) begin
            push(32'h400 + 32'(4 * i), 32'(i), 4'hF);
            tick();
            check("t5_pair_addr", sb2cache_addr, 32'h400 + 32'(4 * i));
            cache2sb_ack = 1'b1;
            tick();
            cache2sb_ack = 1'b0;
        end
        check("t5_empty", 32'(sb_empty), 32'd1);
        push(32'h500, 32'hAAAA_0000, 4'hF);
        push(32'h504, 32'hBBBB_0000, 4'hF);
        push(32'h508, 32'hCCCC_0000, 4'hF);
        lookup(32'h500, 4'hF);
        check("t5_old_hit", 32'(sb_fwd_hit), 32'd1);
        check("t5_old_data", sb_fwd_data, 32'hAAAA_0000);
        lookup(32'h508, 4'h4);
        check("t5_young_data", sb_fwd_data, 32'hCCCC_0000);
        check("t5_busy", 32'(sb2cache_req_valid), 32'd1);
        check("t5_busy_addr", sb2cache_addr, 32'h500);
        check("t5_count", 32'(sb_count), 32'd3);

        // 6: asynchronous reset while busy
        lookup(32'h500, 4'hF);
        reset = 1'b1;
        #1;
        check("t6_req", 32'(sb2cache_req_valid), 32'd0);
        check("t6_addr", sb2cache_addr, 32'd0);
        check("t6_data", sb2cache_data, 32'd0);
        check("t6_mask", 32'(sb2cache_store_byte), 32'd0);
        check("t6_count", 32'(sb_count), 32'd0);
        check("t6_fwd", 32'({sb_fwd_hit, sb_fwd_partial}), 32'd0);
        check("t6_fwd_data", sb_fwd_data, 32'd0);
        #8;
        reset = 1'b0;
        lb2sb_req_valid = 1'b0;
        tick();
        tick();
        check("t6_no_req", 32'(sb2cache_req_valid), 32'd0);
        check("t6_empty", 32'(sb_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
